// File: rtl/plic_mc_if.sv
// -----------------------------------------------------------------------------
// plic_mc_if
// Register-port bundle for the multi-context PLIC. Carries the configuration
// write strobes (priority, trigger mode, enables, thresholds), the per-context
// claim pulses and returned claim IDs, and the completion strobe.
//
// Signal names keep the controller's point of view: *_i are driven by the
// software/bus side (master), *_o are driven by the controller (slave).
//
//   prio_we_i/prio_id_i/prio_wdata_i   write one source priority
//   trig_we_i/trig_wdata_i             write trigger-mode vector (1 = edge)
//   en_we_i/en_ctx_i/en_wdata_i        write one context's enable vector
//   thr_we_i/thr_ctx_i/thr_wdata_i     write one context's threshold
//   claim_req_i                        one-cycle claim pulse per context
//   claim_id_o                         registered claimed ID per context
//   complete_we_i/ctx_i/id_i           completion strobe
// -----------------------------------------------------------------------------
interface plic_mc_if #(
    parameter int NSOURCES   = 32,
    parameter int NCTX       = 2,
    parameter int PRIO_WIDTH = 3,
    parameter int IDW        = $clog2(NSOURCES),
    parameter int CTXW       = (NCTX > 1) ? $clog2(NCTX) : 1
);
    logic                  prio_we_i;
    logic [IDW-1:0]        prio_id_i;
    logic [PRIO_WIDTH-1:0] prio_wdata_i;
    logic                  trig_we_i;
    logic [NSOURCES-1:0]   trig_wdata_i;
    logic                  en_we_i;
    logic [CTXW-1:0]       en_ctx_i;
    logic [NSOURCES-1:0]   en_wdata_i;
    logic                  thr_we_i;
    logic [CTXW-1:0]       thr_ctx_i;
    logic [PRIO_WIDTH-1:0] thr_wdata_i;
    logic [NCTX-1:0]       claim_req_i;
    logic [NCTX*IDW-1:0]   claim_id_o;
    logic                  complete_we_i;
    logic [CTXW-1:0]       complete_ctx_i;
    logic [IDW-1:0]        complete_id_i;

    modport master (
        output prio_we_i, prio_id_i, prio_wdata_i,
        output trig_we_i, trig_wdata_i,
        output en_we_i, en_ctx_i, en_wdata_i,
        output thr_we_i, thr_ctx_i, thr_wdata_i,
        output claim_req_i,
        input  claim_id_o,
        output complete_we_i, complete_ctx_i, complete_id_i
    );

    modport slave (
        input  prio_we_i, prio_id_i, prio_wdata_i,
        input  trig_we_i, trig_wdata_i,
        input  en_we_i, en_ctx_i, en_wdata_i,
        input  thr_we_i, thr_ctx_i, thr_wdata_i,
        input  claim_req_i,
        output claim_id_o,
        input  complete_we_i, complete_ctx_i, complete_id_i
    );
endinterface

// File: rtl/plic_mc.sv
// -----------------------------------------------------------------------------
// plic_mc
// Multi-context platform-level interrupt controller.
//
// Each source i >= 1 passes through a gateway (level or rising-edge) that sets
// a pending bit. Each context selects, among pending sources it has enabled
// whose priority exceeds its threshold, the highest priority (lowest ID on a
// tie). A claim hands that ID out, moves the source from pending to in-flight,
// and the source stays blocked until a completion arrives. Edge sources keep a
// one-deep memory of an edge seen while busy.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   src_i      raw interrupt lines (synchronous to clk_i)
//   reg_if     register/claim/complete port (slave side)
//   ext_irq_o  registered interrupt request per context
// -----------------------------------------------------------------------------
module plic_mc #(
    parameter int NSOURCES   = 32,
    parameter int NCTX       = 2,
    parameter int PRIO_WIDTH = 3,
    parameter int IDW        = $clog2(NSOURCES),
    parameter int CTXW       = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NSOURCES-1:0] src_i,
    plic_mc_if.slave            reg_if,
    output logic [NCTX-1:0]     ext_irq_o
);

    typedef logic [NSOURCES-1:0] src_vec_t;

    // Configuration state
    logic [PRIO_WIDTH-1:0] prio_q [NSOURCES];
    logic [PRIO_WIDTH-1:0] prio_d [NSOURCES];
    src_vec_t              trig_q, trig_d;
    src_vec_t              en_q [NCTX];
    src_vec_t              en_d [NCTX];
    logic [PRIO_WIDTH-1:0] thr_q [NCTX];
    logic [PRIO_WIDTH-1:0] thr_d [NCTX];

    // Gateway / handshake state
    src_vec_t              pending_q, pending_d;
    src_vec_t              in_flight_q, in_flight_d;
    src_vec_t              edge_hold_q, edge_hold_d;
    src_vec_t              src_q;

    // Output registers
    logic [IDW-1:0]        claim_id_q [NCTX];
    logic [IDW-1:0]        claim_id_d [NCTX];
    logic [NCTX-1:0]       ext_irq_q, ext_irq_d;

    // Selection results
    src_vec_t              elig_s [NCTX];
    logic [IDW-1:0]        best_id_s [NCTX];
    logic [PRIO_WIDTH-1:0] best_prio_s;
    src_vec_t              taken_s;
    src_vec_t              rise_s;
    logic                  complete_ok_s;

    // Per-context arbitration; claims resolve in ascending context order so a
    // source granted to a lower context is invisible to higher ones this cycle.
    always_comb begin
        taken_s     = '0;
        best_prio_s = '0;
        for (int c = 0; c < NCTX; c++) begin
            elig_s[c]    = '0;
            best_id_s[c] = '0;
            best_prio_s  = '0;
            for (int i = 0; i < NSOURCES; i++) begin
                // prio > thr also rules out priority 0
                if (pending_q[i] && en_q[c][i] && (prio_q[i] > thr_q[c])) begin
                    elig_s[c][i] = 1'b1;
                    // strict '>' during an ascending scan keeps the lowest ID on ties
                    if (!taken_s[i] && (prio_q[i] > best_prio_s)) begin
                        best_prio_s  = prio_q[i];
                        best_id_s[c] = IDW'(i);
                    end else begin
                        best_prio_s  = best_prio_s;
                    end
                end else begin
                    elig_s[c][i] = 1'b0;
                end
            end
            if (reg_if.claim_req_i[c] && (best_id_s[c] != '0)) begin
                taken_s[best_id_s[c]] = 1'b1;
            end else begin
                taken_s = taken_s;
            end
        end
    end

    // Completion is honoured only for a real source enabled in the completing context
    always_comb begin
        if (reg_if.complete_we_i
            && (reg_if.complete_id_i != '0)
            && (32'(reg_if.complete_id_i) < NSOURCES)
            && (32'(reg_if.complete_ctx_i) < NCTX)) begin
            complete_ok_s = en_q[reg_if.complete_ctx_i][reg_if.complete_id_i];
        end else begin
            complete_ok_s = 1'b0;
        end
    end

    // Configuration register next-state
    always_comb begin
        prio_d = prio_q;
        trig_d = trig_q;
        en_d   = en_q;
        thr_d  = thr_q;
        if (reg_if.prio_we_i && (reg_if.prio_id_i != '0)
            && (32'(reg_if.prio_id_i) < NSOURCES)) begin
            prio_d[reg_if.prio_id_i] = reg_if.prio_wdata_i;
        end else begin
            prio_d = prio_q;
        end
        if (reg_if.trig_we_i) begin
            trig_d = reg_if.trig_wdata_i;
        end else begin
            trig_d = trig_q;
        end
        if (reg_if.en_we_i && (32'(reg_if.en_ctx_i) < NCTX)) begin
            en_d[reg_if.en_ctx_i] = reg_if.en_wdata_i;
        end else begin
            en_d = en_q;
        end
        if (reg_if.thr_we_i && (32'(reg_if.thr_ctx_i) < NCTX)) begin
            thr_d[reg_if.thr_ctx_i] = reg_if.thr_wdata_i;
        end else begin
            thr_d = thr_q;
        end
    end

    // Gateways, claim and completion bookkeeping
    always_comb begin
        rise_s      = src_i & ~src_q;
        pending_d   = pending_q & ~taken_s;
        in_flight_d = in_flight_q;
        edge_hold_d = edge_hold_q;

        for (int i = 0; i < NSOURCES; i++) begin
            if (trig_q[i]) begin
                if (rise_s[i]) begin
                    if (!in_flight_q[i] && !pending_q[i]) begin
                        pending_d[i] = 1'b1;
                    end else begin
                        // one-deep: a second edge while held is simply absorbed
                        edge_hold_d[i] = 1'b1;
                    end
                end else if (edge_hold_q[i] && !in_flight_q[i] && !pending_q[i]) begin
                    // a held edge whose completion raced with its capture
                    pending_d[i]   = 1'b1;
                    edge_hold_d[i] = 1'b0;
                end else begin
                    edge_hold_d[i] = edge_hold_d[i];
                end
            end else begin
                if (src_i[i] && !in_flight_q[i] && !pending_q[i]) begin
                    pending_d[i] = 1'b1;
                end else begin
                    pending_d[i] = pending_d[i];
                end
            end
        end

        // completion first, then new claims, so a same-cycle claim is never undone
        if (complete_ok_s) begin
            in_flight_d[reg_if.complete_id_i] = 1'b0;
            if (edge_hold_q[reg_if.complete_id_i]) begin
                pending_d[reg_if.complete_id_i]   = 1'b1;
                edge_hold_d[reg_if.complete_id_i] = 1'b0;
            end else begin
                edge_hold_d = edge_hold_d;
            end
        end else begin
            in_flight_d = in_flight_d;
        end
        in_flight_d = in_flight_d | taken_s;

        // ID 0 is reserved and never takes part in the handshake
        pending_d[0]   = 1'b0;
        in_flight_d[0] = 1'b0;
        edge_hold_d[0] = 1'b0;
    end

    // Output register next-state: claim IDs hold until the next claim
    always_comb begin
        for (int c = 0; c < NCTX; c++) begin
            if (reg_if.claim_req_i[c]) begin
                claim_id_d[c] = best_id_s[c];
            end else begin
                claim_id_d[c] = claim_id_q[c];
            end
            ext_irq_d[c] = |elig_s[c];
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSOURCES; i++) begin
                prio_q[i] <= '0;
            end
            for (int c = 0; c < NCTX; c++) begin
                en_q[c]       <= '0;
                thr_q[c]      <= '0;
                claim_id_q[c] <= '0;
            end
            trig_q      <= '0;
            pending_q   <= '0;
            in_flight_q <= '0;
            edge_hold_q <= '0;
            src_q       <= '0;
            ext_irq_q   <= '0;
        end else begin
            prio_q      <= prio_d;
            en_q        <= en_d;
            thr_q       <= thr_d;
            claim_id_q  <= claim_id_d;
            trig_q      <= trig_d;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            edge_hold_q <= edge_hold_d;
            src_q       <= src_i;
            ext_irq_q   <= ext_irq_d;
        end
    end

    for (genvar g = 0; g < NCTX; g++) begin : g_claim_out
        assign reg_if.claim_id_o[g*IDW +: IDW] = claim_id_q[g];
    end

    assign ext_irq_o = ext_irq_q;

endmodule

// File: tb/tb_plic_mc.sv
// -----------------------------------------------------------------------------
// tb_plic_mc
// Directed bench for plic_mc. Inputs change and outputs are sampled on the
// falling clock edge; every expected value below is worked out by hand from
// the controller's behaviour.
// -----------------------------------------------------------------------------
module tb_plic_mc;

    localparam int NSOURCES   = 32;
    localparam int NCTX       = 2;
    localparam int PRIO_WIDTH = 3;
    localparam int IDW        = 5;

    logic                clk_i;
    logic                rst_ni;
    logic [NSOURCES-1:0] src_i;
    logic [NCTX-1:0]     ext_irq_o;

    int total;
    int bad;

    plic_mc_if #(.NSOURCES(NSOURCES), .NCTX(NCTX), .PRIO_WIDTH(PRIO_WIDTH)) rif ();

    plic_mc #(.NSOURCES(NSOURCES), .NCTX(NCTX), .PRIO_WIDTH(PRIO_WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .src_i     (src_i),
        .reg_if    (rif),
        .ext_irq_o (ext_irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_i);
    endtask

    task automatic set_prio(input logic [IDW-1:0] id, input logic [PRIO_WIDTH-1:0] v);
        rif.prio_we_i = 1'b1; rif.prio_id_i = id; rif.prio_wdata_i = v;
        tick(1);
        rif.prio_we_i = 1'b0;
    endtask

    task automatic set_en(input logic c, input logic [NSOURCES-1:0] v);
        rif.en_we_i = 1'b1; rif.en_ctx_i = c; rif.en_wdata_i = v;
        tick(1);
        rif.en_we_i = 1'b0;
    endtask

    task automatic set_thr(input logic c, input logic [PRIO_WIDTH-1:0] v);
        rif.thr_we_i = 1'b1; rif.thr_ctx_i = c; rif.thr_wdata_i = v;
        tick(1);
        rif.thr_we_i = 1'b0;
    endtask

    task automatic set_trig(input logic [NSOURCES-1:0] v);
        rif.trig_we_i = 1'b1; rif.trig_wdata_i = v;
        tick(1);
        rif.trig_we_i = 1'b0;
    endtask

    task automatic claim(input logic [NCTX-1:0] mask);
        rif.claim_req_i = mask;
        tick(1);
        rif.claim_req_i = '0;
    endtask

    task automatic complete(input logic c, input logic [IDW-1:0] id);
        rif.complete_we_i = 1'b1; rif.complete_ctx_i = c; rif.complete_id_i = id;
        tick(1);
        rif.complete_we_i = 1'b0;
    endtask

    function automatic logic [31:0] cid(input int c);
        logic [NCTX*IDW-1:0] v;
        v = rif.claim_id_o;
        return 32'(v[c*IDW +: IDW]);
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_ni = 1'b0;
        src_i  = '0;
        rif.prio_we_i = 1'b0; rif.prio_id_i = '0; rif.prio_wdata_i = '0;
        rif.trig_we_i = 1'b0; rif.trig_wdata_i = '0;
        rif.en_we_i = 1'b0; rif.en_ctx_i = '0; rif.en_wdata_i = '0;
        rif.thr_we_i = 1'b0; rif.thr_ctx_i = '0; rif.thr_wdata_i = '0;
        rif.claim_req_i = '0;
        rif.complete_we_i = 1'b0; rif.complete_ctx_i = '0; rif.complete_id_i = '0;

        // reset state
        tick(2);
        check("rst_ext_irq", 32'(ext_irq_o), 32'd0);
        check("rst_claim_id", 32'(rif.claim_id_o), 32'd0);
        rst_ni = 1'b1;
        tick(1);

        // level source 5 in context 0
        set_prio(5'd5, 3'd3);
        set_en(1'b0, 32'h0000_0020);
        src_i[5] = 1'b1;
        tick(1);
        check("lvl_irq_early", 32'(ext_irq_o[0]), 32'd0);
        tick(1);
        check("lvl_irq_up", 32'(ext_irq_o[0]), 32'd1);
        claim(2'b01);
        check("lvl_claim5", cid(0), 32'd5);
        tick(1);
        check("lvl_irq_drop", 32'(ext_irq_o[0]), 32'd0);
        check("lvl_claim_hold", cid(0), 32'd5);
        complete(1'b0, 5'd5);
        tick(1);
        check("lvl_repend_wait", 32'(ext_irq_o[0]), 32'd0);
        tick(1);
        check("lvl_repend_irq", 32'(ext_irq_o[0]), 32'd1);
        src_i[5] = 1'b0;
        claim(2'b01);
        check("lvl_claim5_again", cid(0), 32'd5);
        complete(1'b0, 5'd5);
        set_en(1'b0, 32'h0);
        tick(2);

        // priority and tie-break among 3, 7, 9
        set_prio(5'd3, 3'd2);
        set_prio(5'd7, 3'd5);
        set_prio(5'd9, 3'd5);
        set_en(1'b0, 32'h0000_0288);
        src_i[3] = 1'b1; src_i[7] = 1'b1; src_i[9] = 1'b1;
        tick(2);
        claim(2'b01);
        check("prio_claim7", cid(0), 32'd7);
        claim(2'b01);
        check("prio_claim9", cid(0), 32'd9);
        claim(2'b01);
        check("prio_claim3", cid(0), 32'd3);
        claim(2'b01);
        check("prio_claim0", cid(0), 32'd0);
        check("prio_irq_none", 32'(ext_irq_o[0]), 32'd0);
        src_i[3] = 1'b0; src_i[7] = 1'b0; src_i[9] = 1'b0;
        complete(1'b0, 5'd7);
        complete(1'b0, 5'd9);
        complete(1'b0, 5'd3);
        set_en(1'b0, 32'h0);
        tick(2);

        // threshold: prio == thr does not interrupt, prio > thr does
        set_prio(5'd4, 3'd2);
        set_thr(1'b0, 3'd2);
        set_en(1'b0, 32'h0000_0010);
        src_i[4] = 1'b1;
        tick(3);
        check("thr_equal_blocks", 32'(ext_irq_o[0]), 32'd0);
        set_thr(1'b0, 3'd1);
        tick(1);
        check("thr_lower_irq", 32'(ext_irq_o[0]), 32'd1);
        tick(1);
        check("thr_lower_irq_stays", 32'(ext_irq_o[0]), 32'd1);
        src_i[4] = 1'b0;
        claim(2'b01);
        check("thr_claim4", cid(0), 32'd4);
        complete(1'b0, 5'd4);
        set_en(1'b0, 32'h0);
        set_thr(1'b0, 3'd0);
        tick(2);

        // edge source 6 with one-deep buffering
        set_trig(32'h0000_0040);
        set_prio(5'd6, 3'd4);
        set_en(1'b0, 32'h0000_0040);
        src_i[6] = 1'b1; tick(1); src_i[6] = 1'b0;
        tick(1);
        check("edge_irq_up", 32'(ext_irq_o[0]), 32'd1);
        claim(2'b01);
        check("edge_claim6", cid(0), 32'd6);
        src_i[6] = 1'b1; tick(1); src_i[6] = 1'b0; tick(1);
        src_i[6] = 1'b1; tick(1); src_i[6] = 1'b0; tick(1);
        check("edge_busy_no_irq", 32'(ext_irq_o[0]), 32'd0);
        complete(1'b0, 5'd6);
        tick(1);
        check("edge_repend_irq", 32'(ext_irq_o[0]), 32'd1);
        claim(2'b01);
        check("edge_claim6_again", cid(0), 32'd6);
        complete(1'b0, 5'd6);
        tick(2);
        claim(2'b01);
        check("edge_claim0", cid(0), 32'd0);
        check("edge_irq_none", 32'(ext_irq_o[0]), 32'd0);
        set_trig(32'h0);
        set_en(1'b0, 32'h0);
        tick(2);

        // dual context, simultaneous claim of source 2
        set_prio(5'd2, 3'd3);
        set_en(1'b0, 32'h0000_0004);
        set_en(1'b1, 32'h0000_0004);
        src_i[2] = 1'b1;
        tick(2);
        check("dual_irq_both", 32'(ext_irq_o), 32'd3);
        claim(2'b11);
        check("dual_ctx0_gets2", cid(0), 32'd2);
        check("dual_ctx1_gets0", cid(1), 32'd0);
        set_en(1'b1, 32'h0);
        complete(1'b1, 5'd2);
        tick(3);
        check("dual_bad_complete_ignored", 32'(ext_irq_o[0]), 32'd0);
        complete(1'b0, 5'd2);
        tick(2);
        check("dual_good_complete_repend", 32'(ext_irq_o[0]), 32'd1);
        claim(2'b01);
        check("dual_claim2", cid(0), 32'd2);

        // asynchronous reset while source 2 is in flight
        #2;
        check("pre_rst_claim_id", cid(0), 32'd2);
        rst_ni = 1'b0;
        #1;
        check("async_rst_ext_irq", 32'(ext_irq_o), 32'd0);
        check("async_rst_claim_id", 32'(rif.claim_id_o), 32'd0);
        tick(1);
        rst_ni = 1'b1;
        set_prio(5'd2, 3'd3);
        set_en(1'b0, 32'h0000_0004);
        tick(1);
        check("post_rst_repend_irq", 32'(ext_irq_o[0]), 32'd1);
        claim(2'b01);
        check("post_rst_claim2", cid(0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_mc.md
Name: plic_mc

Overview:
Multi-context platform-level interrupt controller and the parametrised successor to the single-context PLIC. It adds per-context enables and thresholds, per-source level/edge gateways, and a claim/complete handshake that holds a source until software completes it. It sits between the peripheral IRQ lines and the hart(s), driving one external-interrupt line per context, and uses a bus-free register port.

Parameters:
NSOURCES, 32, number of interrupt IDs including reserved ID 0 (source 0 never pends)
NCTX, 2, number of targets/contexts (e.g. M-mode and S-mode per hart)
PRIO_WIDTH, 3, priority bits; 0 = never interrupt
IDW, $clog2(NSOURCES), ID width (derived)
CTXW, max(1,$clog2(NCTX)), context index width (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
src_i  in  NSOURCES  raw interrupt lines, synchronous to clk_i
prio_we_i  in  1  write one source priority
prio_id_i  in  IDW  source ID for priority write
prio_wdata_i  in  PRIO_WIDTH  priority value
trig_we_i  in  1  write trigger-mode vector
trig_wdata_i  in  NSOURCES  1 = rising-edge, 0 = level
en_we_i  in  1  write enable vector of one context
en_ctx_i  in  CTXW  target context
en_wdata_i  in  NSOURCES  enable bits (bit 0 ignored)
thr_we_i  in  1  write one context threshold
thr_ctx_i  in  CTXW  target context
thr_wdata_i  in  PRIO_WIDTH  threshold value
claim_req_i  in  NCTX  one-cycle claim pulse per context
claim_id_o  out  NCTX*IDW  registered claimed ID per context (0 = none)
complete_we_i  in  1  completion strobe
complete_ctx_i  in  CTXW  completing context
complete_id_i  in  IDW  completed source ID
ext_irq_o  out  NCTX  registered interrupt request per context

Behaviour:
- Reset: priorities, trigger modes, enables, thresholds, pending, in_flight, edge_hold, src_q, claim_id_o and ext_irq_o are all 0.
- Config writes take effect on the next cycle. Writes with ID 0 or ctx >= NCTX are ignored.
- Gateway, per source i >= 1:
  - Level mode: pending[i] sets when src_i[i]=1, in_flight[i]=0 and pending[i]=0.
  - Edge mode: a rise is detected as src_i & ~src_q. If in_flight=0 and pending=0, pending sets. Otherwise edge_hold[i] sets (one-deep; further edges are dropped).
- Per-context selection (combinational): candidates are pending & enable[c] with prio > thr[c] (prio 0 never qualifies). The best candidate is the highest priority; ties go to the lowest ID.
- ext_irq_o[c] is registered: high the cycle after context c has a candidate, low the cycle after it has none.
- Claim on claim_req_i[c] at cycle N:
  - At N+1, claim_id_o[c] equals the best ID, or 0 if none.
  - At N+1, pending[best] clears and in_flight[best] sets.
  - claim_id_o[c] holds until the next claim by that context.
- Simultaneous claims: contexts resolve in ascending index. A source taken by a lower context is excluded for higher contexts in the same cycle, which then receive their next best or 0.
- Complete: with complete_we_i, in_flight[id] clears at the next edge, only if enable[complete_ctx_i][id]=1 and id != 0. Otherwise it is ignored.
  - If edge_hold[id]=1 at complete, pending sets and edge_hold clears in the same edge.
  - A level source still high re-pends one cycle after in_flight clears.
- Disabling a source does not clear pending; it only hides it from that context.
- Lowering a priority to 0 does not clear pending.
- Asynchronous reset mid-claim clears all state immediately; outstanding claims are lost.

Test Plan:
- Level, ctx0: prio[5]=3, en0 bit 5 set, thr0=0, src 5 high. Required: ext_irq_o[0]=1 within 3 cycles; claim returns 5; ext_irq_o[0] drops; after complete with src still high, it re-asserts.
- Priority and tie-break: prio[3]=2, prio[7]=5, prio[9]=5, all pending. Required: claims return 7, then 9, then 3; a fourth claim returns 0.
- Threshold: prio[4]=2, thr0=2. Required: no IRQ. Write thr0=1. Required: ext_irq_o[0]=1 on the following cycles.
- Edge buffering: source 6 in edge mode, claimed, then two pulses while in flight. Required: after complete, exactly one re-pend; claim returns 6 once more, then 0.
- Dual context: source 2 enabled in both contexts, both claim in the same cycle. Required: ctx0 gets 2 and ctx1 gets 0. Complete from a context with source 2 disabled is ignored; in_flight stays 1.
- Reset mid-claim: assert rst_ni low asynchronously while in_flight. Required: all outputs are 0 immediately. After release, the still-high level source re-pends normally.
